// File: rtl/pcie_cfg_pkg.sv
// Shared definitions for the cfg_mgmt sweep: FSM state encoding, status word layout
// and the BAR probe pattern.
package pcie_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_RD_REQ      = 4'd1,
    ST_RD_WAIT     = 4'd2,
    ST_PRB_WR      = 4'd3,
    ST_PRB_WR_WAIT = 4'd4,
    ST_PRB_RD      = 4'd5,
    ST_PRB_RD_WAIT = 4'd6,
    ST_RST_WR      = 4'd7,
    ST_RST_WR_WAIT = 4'd8,
    ST_PUSH        = 4'd9,
    ST_NEXT        = 4'd10,
    ST_DONE        = 4'd11
  } state_e;

  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_BUSY_BIT  = 1;
  localparam int STAT_TMO_BIT   = 2;
  localparam int STAT_LINK_BIT  = 3;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_ADDR_LSB  = 8;
  localparam int STAT_FUNC_LSB  = 18;

  localparam logic [31:0] PROBE_PATTERN = 32'hFFFF_FFFF;

  function automatic logic is_wait_st(input state_e s);
    return (s == ST_RD_WAIT) || (s == ST_PRB_WR_WAIT) ||
           (s == ST_PRB_RD_WAIT) || (s == ST_RST_WR_WAIT);
  endfunction

  function automatic logic is_req_st(input state_e s);
    return (s == ST_RD_REQ) || (s == ST_PRB_WR) ||
           (s == ST_PRB_RD) || (s == ST_RST_WR);
  endfunction

endpackage

// File: rtl/cfg_mgmt_xact.sv
// Single cfg_mgmt access engine: registered strobes, done detection and a 16-bit
// WAIT-state timer; done/timeout flags are only meaningful while in_wait is high.
module cfg_mgmt_xact #(
  parameter int TIMEOUT = 255
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic        issue_rd,
  input  logic        issue_wr,
  input  logic [31:0] issue_wdata,
  input  logic        in_wait,
  input  logic        cfg_mgmt_read_write_done,
  input  logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read,
  output logic        cfg_mgmt_write,
  output logic [31:0] cfg_mgmt_write_data,
  output logic [3:0]  cfg_mgmt_byte_enable,
  output logic        xact_done,
  output logic        xact_timeout,
  output logic [31:0] xact_data
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [15:0] timer_q;

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      cfg_mgmt_read        <= 1'b0;
      cfg_mgmt_write       <= 1'b0;
      cfg_mgmt_write_data  <= '0;
      cfg_mgmt_byte_enable <= 4'h0;
      timer_q              <= '0;
    end else begin
      // Read has priority so the two strobes can never be high together.
      cfg_mgmt_read        <= issue_rd;
      cfg_mgmt_write       <= issue_wr & ~issue_rd;
      cfg_mgmt_write_data  <= (issue_wr & ~issue_rd) ? issue_wdata : '0;
      cfg_mgmt_byte_enable <= (issue_rd | issue_wr) ? 4'hF : 4'h0;
      timer_q              <= in_wait ? timer_q + 16'd1 : 16'd0;
    end
  end

  // A done in the final permitted WAIT cycle beats the timeout.
  assign xact_done    = in_wait & cfg_mgmt_read_write_done;
  assign xact_timeout = in_wait & ~cfg_mgmt_read_write_done & (timer_q == TIMER_LAST);
  assign xact_data    = cfg_mgmt_read_data;

endmodule

// File: rtl/pcie_cfg_mgmt_sweep.sv
// Sweeps a DWORD window of config space across functions via cfg_mgmt and streams each
// read result; define CFG_MGMT_BAR_PROBE_EN to add the per-address BAR size probe.
module pcie_cfg_mgmt_sweep
  import pcie_cfg_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(10'h028),
  parameter int                NUM_FUNC   = 1,
  parameter int                TIMEOUT    = 255
) (
  input  logic              user_clk,
  input  logic              user_reset_n,
  input  logic              user_lnk_up,
  input  logic              start,
  output logic [ADDR_W-1:0] cfg_mgmt_addr,
  output logic [7:0]        cfg_mgmt_function_number,
  output logic              cfg_mgmt_write,
  output logic [31:0]       cfg_mgmt_write_data,
  output logic [3:0]        cfg_mgmt_byte_enable,
  output logic              cfg_mgmt_read,
  output logic              cfg_mgmt_debug_access,
  input  logic [31:0]       cfg_mgmt_read_data,
  input  logic              cfg_mgmt_read_write_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_func,
  output logic [31:0]       res_data,
  output logic [31:0]       res_probe,
  output logic              res_err,
  output logic [31:0]       cfg2ctr_status
);

  localparam logic [7:0] FUNC_LAST = 8'(NUM_FUNC - 1);

`ifdef CFG_MGMT_BAR_PROBE_EN
  localparam state_e AFTER_RD = ST_PRB_WR;
`else
  localparam state_e AFTER_RD = ST_PUSH;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        func_q;
  logic [31:0]       data_q, probe_q;
  logic              err_q, done_q, timeout_err_q, link_err_q;
  logic              link_drop, in_wait;
  logic              issue_rd, issue_wr;
  logic [31:0]       issue_wdata;
  logic              x_done, x_timeout;
  logic [31:0]       x_data;

  assign link_drop = (state_q != ST_IDLE) && !user_lnk_up;
  assign in_wait   = is_wait_st(state_q);

  always_comb begin
    state_d = state_q;
    if (link_drop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:        if (start && user_lnk_up) state_d = ST_RD_REQ;
        ST_RD_REQ:      state_d = ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (x_done)         state_d = AFTER_RD;
          else if (x_timeout) state_d = ST_PUSH;
        end
`ifdef CFG_MGMT_BAR_PROBE_EN
        ST_PRB_WR:      state_d = ST_PRB_WR_WAIT;
        ST_PRB_WR_WAIT: begin
          if (x_done)         state_d = ST_PRB_RD;
          else if (x_timeout) state_d = ST_PUSH;
        end
        ST_PRB_RD:      state_d = ST_PRB_RD_WAIT;
        ST_PRB_RD_WAIT: begin
          if (x_done)         state_d = ST_RST_WR;
          else if (x_timeout) state_d = ST_PUSH;
        end
        ST_RST_WR:      state_d = ST_RST_WR_WAIT;
        ST_RST_WR_WAIT: if (x_done || x_timeout) state_d = ST_PUSH;
`endif
        ST_PUSH:        if (res_ready) state_d = ST_NEXT;
        ST_NEXT:        state_d = ((addr_q < END_ADDR) || (func_q < FUNC_LAST)) ? ST_RD_REQ : ST_DONE;
        ST_DONE:        state_d = ST_IDLE;
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are launched from the next state so they appear as flops in the REQ cycle.
  always_comb begin
    issue_rd    = (state_d == ST_RD_REQ);
    issue_wr    = 1'b0;
    issue_wdata = '0;
`ifdef CFG_MGMT_BAR_PROBE_EN
    issue_rd    = (state_d == ST_RD_REQ) || (state_d == ST_PRB_RD);
    issue_wr    = (state_d == ST_PRB_WR) || (state_d == ST_RST_WR);
    issue_wdata = (state_d == ST_PRB_WR) ? PROBE_PATTERN : data_q;
`endif
  end

  cfg_mgmt_xact #(
    .TIMEOUT (TIMEOUT)
  ) u_xact (
    .user_clk                 (user_clk),
    .user_reset_n             (user_reset_n),
    .issue_rd                 (issue_rd),
    .issue_wr                 (issue_wr),
    .issue_wdata              (issue_wdata),
    .in_wait                  (in_wait),
    .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done),
    .cfg_mgmt_read_data       (cfg_mgmt_read_data),
    .cfg_mgmt_read            (cfg_mgmt_read),
    .cfg_mgmt_write           (cfg_mgmt_write),
    .cfg_mgmt_write_data      (cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
    .xact_done                (x_done),
    .xact_timeout             (x_timeout),
    .xact_data                (x_data)
  );

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state_q               <= ST_IDLE;
      addr_q                <= '0;
      func_q                <= '0;
      data_q                <= '0;
      probe_q               <= '0;
      err_q                 <= 1'b0;
      done_q                <= 1'b0;
      timeout_err_q         <= 1'b0;
      link_err_q            <= 1'b0;
      res_valid             <= 1'b0;
      cfg_mgmt_debug_access <= 1'b0;
    end else begin
      state_q               <= state_d;
      res_valid             <= (state_d == ST_PUSH);
      cfg_mgmt_debug_access <= is_req_st(state_d) || is_wait_st(state_d);
      if (link_drop) begin
        link_err_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && user_lnk_up) begin
              done_q        <= 1'b0;
              timeout_err_q <= 1'b0;
              link_err_q    <= 1'b0;
              addr_q        <= START_ADDR;
              func_q        <= '0;
            end
          end
          ST_RD_REQ: begin
            err_q   <= 1'b0;
            data_q  <= '0;
            probe_q <= '0;
          end
          ST_RD_WAIT: if (x_done) data_q <= x_data;
`ifdef CFG_MGMT_BAR_PROBE_EN
          ST_PRB_RD_WAIT: if (x_done) probe_q <= x_data;
`endif
          ST_NEXT: begin
            if (addr_q < END_ADDR) begin
              addr_q <= addr_q + 1'b1;
            end else begin
              addr_q <= START_ADDR;
              if (func_q < FUNC_LAST) func_q <= func_q + 8'd1;
            end
          end
          ST_DONE: done_q <= 1'b1;
          default: ;
        endcase
        // A timed-out access reports zero data and abandons any remaining probe steps.
        if (x_timeout) begin
          timeout_err_q <= 1'b1;
          err_q         <= 1'b1;
          data_q        <= '0;
          probe_q       <= '0;
        end
      end
    end
  end

  assign cfg_mgmt_addr            = addr_q;
  assign cfg_mgmt_function_number = func_q;
  assign res_addr                 = addr_q;
  assign res_func                 = func_q;
  assign res_data                 = data_q;
  assign res_probe                = probe_q;
  assign res_err                  = err_q;

  always_comb begin
    cfg2ctr_status                             = '0;
    cfg2ctr_status[STAT_DONE_BIT]              = done_q;
    cfg2ctr_status[STAT_BUSY_BIT]              = (state_q != ST_IDLE);
    cfg2ctr_status[STAT_TMO_BIT]               = timeout_err_q;
    cfg2ctr_status[STAT_LINK_BIT]              = link_err_q;
    cfg2ctr_status[STAT_STATE_LSB +: 4]        = state_q;
    cfg2ctr_status[STAT_ADDR_LSB +: 10]        = 10'(addr_q);
    cfg2ctr_status[STAT_FUNC_LSB +: 8]         = func_q;
  end

endmodule

// File: tb/tb_pcie_cfg_mgmt_sweep.sv
// Scoreboard bench for pcie_cfg_mgmt_sweep: expected results are queued per sweep from
// a per-address delay plan and config-space model, and a monitor checks the result stream.
module tb_pcie_cfg_mgmt_sweep;

  localparam int SA  = 0;
  localparam int EA  = 3;
  localparam int NA  = EA - SA + 1;
  localparam int NF  = 2;
  localparam int TMO = 10;
  localparam logic [31:0] SIZE_MASK = 32'hFFFF_F000;
`ifdef CFG_MGMT_BAR_PROBE_EN
  localparam bit PROBE_EN = 1'b1;
`else
  localparam bit PROBE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  addr;
    logic [7:0]  func;
    logic [31:0] data;
    logic [31:0] probe;
    logic        err;
  } res_t;

  logic        user_clk = 1'b0;
  logic        user_reset_n, user_lnk_up, start;
  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_debug_access;
  logic [31:0] cfg_mgmt_write_data, cfg_mgmt_read_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read_write_done;
  logic        res_valid, res_ready, res_err;
  logic [9:0]  res_addr;
  logic [7:0]  res_func;
  logic [31:0] res_data, res_probe, cfg2ctr_status;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cyc = -100;
  int          plan [NF][NA];
  logic [31:0] mem  [NF][NA];
  bit          pmode[NF][NA];
  res_t        sb_q[$];
  bit          exp_to;
  int          ready_mode = 0;
  int          stall_left = 0;

  pcie_cfg_mgmt_sweep #(
    .ADDR_W(10), .START_ADDR(10'(SA)), .END_ADDR(10'(EA)), .NUM_FUNC(NF), .TIMEOUT(TMO)
  ) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up), .start(start),
    .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_function_number(cfg_mgmt_function_number),
    .cfg_mgmt_write(cfg_mgmt_write), .cfg_mgmt_write_data(cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable), .cfg_mgmt_read(cfg_mgmt_read),
    .cfg_mgmt_debug_access(cfg_mgmt_debug_access), .cfg_mgmt_read_data(cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_func(res_func),
    .res_data(res_data), .res_probe(res_probe), .res_err(res_err), .cfg2ctr_status(cfg2ctr_status)
  );

  always #5 user_clk = ~user_clk;

  initial forever begin
    @(posedge user_clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every function/address of the window in sweep order, one result each.
  task automatic model_sweep();
    exp_to = 1'b0;
    for (int f = 0; f < NF; f++) begin
      for (int a = 0; a < NA; a++) begin
        res_t r;
        r.addr  = 10'(SA + a);
        r.func  = 8'(f);
        r.err   = (plan[f][a] > TMO);
        r.data  = r.err ? 32'h0 : mem[f][a];
        r.probe = (PROBE_EN && !r.err) ? SIZE_MASK : 32'h0;
        if (r.err) exp_to = 1'b1;
        sb_q.push_back(r);
      end
    end
  endtask

  task automatic fill_plan(input int d);
    for (int f = 0; f < NF; f++)
      for (int a = 0; a < NA; a++) plan[f][a] = d;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cfg2ctr_status[0] && n < 4000) begin
      @(negedge user_clk);
      n++;
    end
    #1;
    chk({tag, " done"}, 64'(cfg2ctr_status[0]), 64'(1));
    chk({tag, " busy"}, 64'(cfg2ctr_status[1]), 64'(0));
    chk({tag, " timeout_err"}, 64'(cfg2ctr_status[2]), 64'(exp_to));
    chk({tag, " link_err"}, 64'(cfg2ctr_status[3]), 64'(0));
    chk({tag, " results left"}, 64'(sb_q.size()), 64'(0));
  endtask

  task automatic run_sweep(input string tag, input bit poke);
    model_sweep();
    @(negedge user_clk);
    start = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    #1;
    chk({tag, " start->read"}, 64'(cfg_mgmt_read), 64'(1));
    if (poke) begin
      repeat (6) @(negedge user_clk);
      start = 1'b1;
      @(negedge user_clk);
      start = 1'b0;
    end
    wait_done(tag);
  endtask

  // Config-space responder: done arrives plan[f][a] cycles after a sweep read strobe.
  initial begin
    int f, a, cnt;
    logic [31:0] rsp;
    cfg_mgmt_read_write_done = 1'b0;
    cfg_mgmt_read_data = '0;
    cnt = 0;
    rsp = '0;
    forever begin
      @(negedge user_clk);
      cfg_mgmt_read_write_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          cfg_mgmt_read_write_done = 1'b1;
          cfg_mgmt_read_data = rsp;
          done_cyc = cyc;
        end
      end
      if (user_reset_n && (cfg_mgmt_read || cfg_mgmt_write)) begin
        f = int'(cfg_mgmt_function_number);
        a = int'(cfg_mgmt_addr) - SA;
        if (f >= NF || a < 0 || a >= NA) begin
          chk("access in window", {cfg_mgmt_function_number, 46'(0), cfg_mgmt_addr}, 64'(0));
        end else if (cfg_mgmt_write) begin
          if (cfg_mgmt_write_data == 32'hFFFF_FFFF) begin
            pmode[f][a] = 1'b1;
          end else begin
            chk("restore write data", 64'(cfg_mgmt_write_data), 64'(mem[f][a]));
            pmode[f][a] = 1'b0;
          end
          rsp = '0;
          cnt = 1;
        end else begin
          rsp = pmode[f][a] ? SIZE_MASK : mem[f][a];
          cnt = pmode[f][a] ? 1 : plan[f][a];
        end
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge user_clk);
      case (ready_mode)
        1:       res_ready = 1'($urandom_range(0, 1));
        2: begin
          if (res_valid && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: res_ready = 1'b1;
      endcase
    end
  end

  // Monitor: protocol rules every cycle, and payload against the scoreboard on each transfer.
  initial begin
    bit   prev_valid, prev_ready;
    res_t held, cur, r;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    held = '0;
    forever begin
      @(negedge user_clk);
      #1;
      if (user_reset_n) begin
        if (cfg_mgmt_read && cfg_mgmt_write) chk("strobe overlap", 64'(1), 64'(0));
        if (cfg_mgmt_read || cfg_mgmt_write) chk("byte_enable", 64'(cfg_mgmt_byte_enable), 64'hF);
        if (!PROBE_EN && (cfg_mgmt_write || cfg_mgmt_write_data != 0))
          chk("write path idle", {31'(0), cfg_mgmt_write, cfg_mgmt_write_data}, 64'(0));
        cur = {res_addr, res_func, res_data, res_probe, res_err};
        if (res_valid) begin
          if (prev_valid && !prev_ready) chk("payload stable", 64'(cur != held), 64'(0));
          if (cfg_mgmt_read || cfg_mgmt_write) chk("no access while pushing", 64'(1), 64'(0));
          if (!prev_valid && !PROBE_EN && sb_q.size() > 0 && !sb_q[0].err)
            chk("done->valid latency", 64'(cyc - done_cyc), 64'(1));
          if (res_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected result: addr %0h func %0h, none expected", res_addr, res_func);
            end else begin
              r = sb_q.pop_front();
              chk("res_addr", 64'(res_addr), 64'(r.addr));
              chk("res_func", 64'(res_func), 64'(r.func));
              chk("res_data", 64'(res_data), 64'(r.data));
              chk("res_probe", 64'(res_probe), 64'(r.probe));
              chk("res_err", 64'(res_err), 64'(r.err));
            end
          end
        end
        prev_valid = res_valid;
        prev_ready = res_ready;
        held = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int choices[9];
    choices = '{1, 2, 3, 4, 6, 9, 10, 11, 1000};
    user_reset_n = 1'b0;
    user_lnk_up = 1'b1;
    start = 1'b1;
    for (int f = 0; f < NF; f++)
      for (int a = 0; a < NA; a++) begin
        mem[f][a] = $urandom;
        pmode[f][a] = 1'b0;
      end
    mem[0][0] = 32'hE000_000C;
    fill_plan(2);

    repeat (4) @(negedge user_clk);
    #1;
    chk("reset status", 64'(cfg2ctr_status), 64'(0));
    chk("reset res_valid", 64'(res_valid), 64'(0));
    chk("reset read", 64'(cfg_mgmt_read), 64'(0));
    chk("reset debug", 64'(cfg_mgmt_debug_access), 64'(0));
    chk("reset be", 64'(cfg_mgmt_byte_enable), 64'(0));
    chk("reset res_data", 64'(res_data), 64'(0));
    @(negedge user_clk);
    start = 1'b0;
    user_reset_n = 1'b1;
    repeat (2) @(negedge user_clk);

    run_sweep("base", 1'b0);

    fill_plan(2);
    plan[0][2] = 1000;
    plan[1][1] = TMO;
    plan[1][2] = TMO + 1;
    run_sweep("timeout", 1'b0);

    fill_plan(2);
    ready_mode = 2;
    stall_left = 20;
    run_sweep("stall", 1'b0);

    for (int t = 0; t < 3; t++) begin
      for (int f = 0; f < NF; f++)
        for (int a = 0; a < NA; a++) plan[f][a] = choices[$urandom_range(0, 8)];
      ready_mode = 1;
      run_sweep("random", 1'b1);
    end
    ready_mode = 0;

    @(negedge user_clk);
    user_lnk_up = 1'b0;
    start = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    repeat (3) @(negedge user_clk);
    #1;
    chk("start w/o link busy", 64'(cfg2ctr_status[1]), 64'(0));
    chk("start w/o link done kept", 64'(cfg2ctr_status[0]), 64'(1));
    user_lnk_up = 1'b1;

    fill_plan(1000);
    @(negedge user_clk);
    start = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    @(negedge user_clk);
    user_lnk_up = 1'b0;
    @(negedge user_clk);
    #1;
    chk("linkdrop read", 64'(cfg_mgmt_read), 64'(0));
    chk("linkdrop write", 64'(cfg_mgmt_write), 64'(0));
    chk("linkdrop res_valid", 64'(res_valid), 64'(0));
    chk("linkdrop link_err", 64'(cfg2ctr_status[3]), 64'(1));
    chk("linkdrop busy", 64'(cfg2ctr_status[1]), 64'(0));
    chk("linkdrop done", 64'(cfg2ctr_status[0]), 64'(0));
    repeat (20) @(negedge user_clk);
    user_lnk_up = 1'b1;
    chk("linkdrop no result", 64'(sb_q.size()), 64'(0));

    fill_plan(1);
    run_sweep("recover", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
